// File: rtl/interval_timer.sv
// interval_timer: tick-driven interval counter with one-shot and auto-reload
// modes, a one-cycle expire pulse and an optional sticky interrupt flag.
// Optional feature macro: INTERVAL_TIMER_IRQ_EN (enables the sticky irq;
// when undefined irq is tied low and irq_clr is ignored).
module interval_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] period,
    input  logic             irq_clr,
    output logic             busy,
    output logic [WIDTH-1:0] remain,
    output logic             expire,
    output logic             irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic             expire_q, expire_d;

    // State, count and latched configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            remain_q   <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            expire_q   <= expire_d;
        end
    end

    // Next-state logic; event priority is stop, then start, then tick.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        expire_d   = 1'b0;
        if (stop) begin
            // Abort; in IDLE this leaves everything as it was.
            if (state_q == RUN) begin
                state_d  = IDLE;
                remain_d = '0;
            end
        end else if (start && (period != '0)) begin
            // Start or restart; a coincident expiring tick is swallowed.
            state_d    = RUN;
            remain_d   = period;
            period_d   = period;
            periodic_d = periodic;
        end else if (tick && (state_q == RUN)) begin
            if (remain_q > WIDTH'(1)) begin
                remain_d = remain_q - WIDTH'(1);
            end else begin
                // remain is never 0 in RUN, so this is the last tick.
                expire_d = 1'b1;
                if (periodic_q) begin
                    remain_d = period_q;
                end else begin
                    remain_d = '0;
                    state_d  = IDLE;
                end
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign remain = remain_q;
    assign expire = expire_q;

`ifdef INTERVAL_TIMER_IRQ_EN
    logic irq_q;

    // Sticky flag: set alongside expire, cleared by irq_clr, set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (expire_d) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed vector table plus randomized run against a
// behavioural model of the interval timer.
module tb_interval_timer;

    localparam int W = 8;
`ifdef INTERVAL_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] period;
    logic         irq_clr;
    logic         busy;
    logic [W-1:0] remain;
    logic         expire;
    logic         irq;

    int errors = 0;
    int checks = 0;

    interval_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .irq_clr  (irq_clr),
        .busy     (busy),
        .remain   (remain),
        .expire   (expire),
        .irq      (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a count of ticks left in the current interval
    bit           m_busy;
    int           m_left;
    int           m_per;
    bit           m_mode;
    bit           m_expire;
    bit           m_irq;

    task automatic model_update();
        bit fired;
        fired = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_left = 0; m_per = 0; m_mode = 0; m_irq = 0;
        end else if (stop) begin
            m_busy = 0;
            m_left = 0;
        end else if (start && period != 0) begin
            m_per  = int'(period);
            m_mode = periodic;
            m_left = m_per;
            m_busy = 1;
        end else if (tick && m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                fired = 1'b1;
                if (m_mode) m_left = m_per;
                else m_busy = 0;
            end
        end
        m_expire = fired;
        if (rst_n && IRQ_ON) begin
            if (fired) m_irq = 1;
            else if (irq_clr) m_irq = 0;
        end
    endtask

    // Driver: one clock edge with the currently applied inputs
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit st, input bit sp, input bit tk,
                         input bit pm, input logic [W-1:0] pv, input bit ic);
        rst_n = r; start = st; stop = sp; tick = tk;
        periodic = pm; period = pv; irq_clr = ic;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vector table
    typedef struct {
        bit           rst_n, start, stop, tick, periodic, irq_clr;
        logic [W-1:0] period;
        bit           e_busy;
        logic [W-1:0] e_remain;
        bit           e_expire, e_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit st, input bit sp, input bit tk,
                                input bit pm, input int pv, input bit ic,
                                input bit eb, input int er, input bit ee, input bit ei);
        vec_t v;
        v.rst_n = r; v.start = st; v.stop = sp; v.tick = tk; v.periodic = pm;
        v.period = W'(pv); v.irq_clr = ic;
        v.e_busy = eb; v.e_remain = W'(er); v.e_expire = ee; v.e_irq = ei;
        return v;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        //            rst st sp tk pm per ic | busy rem exp irq(when enabled)
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 1, 0, 0, 0, 3, 0,  1, 3, 0, 0)); // one-shot start
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1)); // expire, idle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0)); // irq_clr
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0)); // tick in idle
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0)); // start period 0
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0)); // stop in idle
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, 0,  1, 2, 0, 0)); // periodic start
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1,  1, 2, 1, 1)); // expire + clr: set wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 2, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0)); // later clr
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 7, 0,  0, 0, 0, 0)); // stop beats all
        tbl.push_back(mk(1, 1, 0, 0, 0, 6, 0,  1, 6, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 5, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 10, 0, 1, 10, 0, 0)); // restart at 5
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0)); // reset mid-run
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 4, 0,  1, 4, 0, 0)); // start swallows expiry
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0)); // reset on last tick
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].stop, tbl[i].tick,
                  tbl[i].periodic, tbl[i].period, tbl[i].irq_clr);
            step();
            check($sformatf("vec%0d busy", i),   int'(busy),   int'(tbl[i].e_busy));
            check($sformatf("vec%0d remain", i), int'(remain), int'(tbl[i].e_remain));
            check($sformatf("vec%0d expire", i), int'(expire), int'(tbl[i].e_expire));
            check($sformatf("vec%0d irq", i),    int'(irq),    int'(tbl[i].e_irq & IRQ_ON));
        end

        // Randomized run against the model
        for (int i = 0; i < 2000; i++) begin
            int pv;
            pv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)),
                  W'(pv),
                  ($urandom_range(0, 7) == 0));
            step();
            check("rand busy",   int'(busy),   int'(m_busy));
            check("rand remain", int'(remain), m_left);
            check("rand expire", int'(expire), int'(m_expire));
            check("rand irq",    int'(irq),    int'(m_irq));
        end

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the period/remaining-count width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port tick  input  1  time-base enable, one-cycle pulse driven by the upstream prescaler counter's carry.
REQ-005 The block SHALL have port start  input  1  load period and begin/restart timing.
REQ-006 The block SHALL have port stop  input  1  abort timing.
REQ-007 The block SHALL have port periodic  input  1  sampled with start: 1 = auto-reload, 0 = one-shot.
REQ-008 The block SHALL have port period  input  WIDTH  tick count per interval, sampled with start.
REQ-009 The block SHALL have port irq_clr  input  1  clears sticky irq.
REQ-010 The block SHALL have port busy  output  1  high in RUN state.
REQ-011 The block SHALL have port remain  output  WIDTH  ticks left in current interval.
REQ-012 The block SHALL have port expire  output  1  one-cycle pulse on interval end.
REQ-013 The block SHALL have port irq  output  1  sticky expiry flag.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE, RUN; busy = (state == RUN), registered.
REQ-015 The block SHALL, in IDLE on start with period != 0, latch period and periodic internally, set remain <= period, and enter RUN on the next edge.
REQ-016 The block SHALL ignore start with period == 0: remain its state, produce no expire.
REQ-017 The block SHALL ignore tick in IDLE.
REQ-018 The block SHALL, in RUN on tick with remain > 1, decrement remain by 1.
REQ-019 The block SHALL, in RUN on tick with remain == 1, assert expire for exactly one cycle, registered, in the cycle following the sampling edge.
REQ-020 The block SHALL, on that expiring tick, reload remain <= latched period and stay in RUN if periodic was latched 1; otherwise set remain <= 0 and return to IDLE.
REQ-021 The block SHALL apply priority stop > start > tick when events coincide in the same cycle.
REQ-022 The block SHALL, on stop in RUN, return to IDLE with remain <= 0 and no expire, even when tick with remain == 1 coincides.
REQ-023 The block SHALL, on start in RUN with period != 0, relatch period and periodic, reload remain, stay in RUN, and suppress any coincident expiry.
REQ-024 The block SHALL treat stop in IDLE as a no-op.
REQ-025 The block SHALL never let remain wrap: no decrement below 1 in RUN, and remain is 0 in IDLE.

Reset
REQ-026 The block SHALL, with rst_n low at a clk edge, force IDLE, busy=0, remain=0, expire=0, irq=0, and clear the latched period and mode.
REQ-027 The block SHALL let reset abort RUN at any point with no expire pulse.
REQ-028 The block SHALL behave from the first edge after rst_n rises exactly as from power-on.

Configuration
REQ-029 The block SHALL, with macro INTERVAL_TIMER_IRQ_EN defined, set irq on the cycle expire asserts and clear it the cycle after irq_clr is sampled high, with set winning over a simultaneous clear.
REQ-030 The block SHALL, without INTERVAL_TIMER_IRQ_EN, tie irq to 0 and ignore irq_clr; both ports remain present.

Verification
REQ-031 The bench SHALL cover one-shot: start, period=3, periodic=0, then 3 ticks -> remain 3,2,1, expire pulses one cycle after the 3rd tick, busy drops to 0 at the same time, remain=0.
REQ-032 The bench SHALL cover periodic: start, period=2, periodic=1, then 6 ticks -> expire after ticks 2, 4, 6, busy stays 1, remain reloads to 2 each time.
REQ-033 The bench SHALL cover stop priority: in RUN with remain=1, assert tick, stop and start together -> no expire, IDLE, remain=0.
REQ-034 The bench SHALL cover restart: in RUN with remain=5, start with period=10 -> remain=10, busy=1, no expire.
REQ-035 The bench SHALL cover zero/idle/reset: start with period=0 -> stays IDLE; ticks in IDLE -> no change; rst_n low mid-RUN -> all outputs 0 next cycle, no expire.
REQ-036 The bench SHALL cover irq with INTERVAL_TIMER_IRQ_EN: expire coincides with irq_clr -> irq=1; a later irq_clr -> irq=0; without the macro -> irq stays 0 throughout.
